shift_transmitter: RTL

Parametrised parallel-to-serial shifter for the JTAG data path. It accepts a WIDTH-bit word through a ready/load handshake, then drives it out one bit per enabled clock, MSB-first or LSB-first, and pulses `done` in the cycle that presents the last bit. It sits between the user data registers and the TAP's TDO mux, with `enable` driven by the TAP's Shift-DR qualifier.

---
 rtl/shift_transmitter.sv | 115 +++++++++++
 1 files changed

// File: rtl/shift_transmitter.sv
// Parallel-to-serial shifter for the JTAG data path: accepts a word on ready/load and shifts it out on enable.
// Optional full-duplex capture of a serial input is enabled by defining SHIFT_TRANSMITTER_CAPTURE_EN.
module shift_transmitter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [WIDTH-1:0]               in,
  output logic                           ready,
  input  logic                           enable,
  output logic                           out,
  output logic                           done,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bits_left
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
  ,
  input  logic                           sin,
  output logic [WIDTH-1:0]               captured,
  output logic                           captured_valid
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic             out_next;
  logic             done_next;
  logic [CW-1:0]    bits_next;

`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
  logic [WIDTH-1:0] cap, cap_next;
  logic [WIDTH-1:0] captured_next;
  logic             captured_valid_next;
`endif

  // Handshake status is decoded straight from the state register.
  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // Next-state and datapath update; done is a pulse so it defaults low.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    out_next   = out;
    done_next  = 1'b0;
    bits_next  = bits_left;
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
    cap_next            = cap;
    captured_next       = captured;
    captured_valid_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          sr_next    = in;
          bits_next  = CW'(WIDTH);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (enable && (bits_left != CW'(0))) begin
          out_next  = LSB_FIRST ? sr[0] : sr[WIDTH-1];
          sr_next   = LSB_FIRST ? (sr >> 1) : (sr << 1);
          bits_next = bits_left - CW'(1);
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
          // First received bit lands where the first sent bit came from.
          cap_next = LSB_FIRST ? ((cap >> 1) | (WIDTH'(sin) << (WIDTH - 1)))
                               : ((cap << 1) | WIDTH'(sin));
`endif
          if (bits_left == CW'(1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
            captured_next       = cap_next;
            captured_valid_next = 1'b1;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      out       <= 1'b0;
      done      <= 1'b0;
      bits_left <= '0;
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
      cap            <= '0;
      captured       <= '0;
      captured_valid <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      sr        <= sr_next;
      out       <= out_next;
      done      <= done_next;
      bits_left <= bits_next;
`ifdef SHIFT_TRANSMITTER_CAPTURE_EN
      cap            <= cap_next;
      captured       <= captured_next;
      captured_valid <= captured_valid_next;
`endif
    end
  end

endmodule
